// File: rtl/riscv_pkg.sv
// ============================================================================
// Module : riscv_pkg
// Shared datapath width, ALU opcode set and arbiter state encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  localparam alu_op_t ALU_OP_LAST = ALU_AND;

  typedef enum logic [0:0] {
    ARB_EMPTY = 1'b0,
    ARB_FULL  = 1'b1
  } arb_state_t;

  // Encodings past the last defined opcode carry no ALU meaning.
  function automatic logic op_is_illegal(input alu_op_t op);
    return 4'(op) > 4'(ALU_OP_LAST);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Round-robin picker: first set request at or after i_ptr (mod NREQ) wins.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [1:0]      i_ptr,
  output logic [NREQ-1:0] o_gnt
);

  logic w_found;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!w_found && i_req[j] && (j == ((int'(i_ptr) + k) % NREQ))) begin
          o_gnt[j] = 1'b1;
          w_found  = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module : alu_arbiter
// Shares one combinational ALU among NREQ requesters with a 1-deep response.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_arbiter
  import riscv_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int TAGW = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NREQ-1:0]                req_valid_i,
  output logic [NREQ-1:0]                req_ready_o,
  input  alu_op_t [NREQ-1:0]             req_op_i,
  input  logic [NREQ-1:0][XLEN-1:0]      req_a_i,
  input  logic [NREQ-1:0][XLEN-1:0]      req_b_i,
  input  logic [NREQ-1:0][TAGW-1:0]      req_tag_i,
  output alu_op_t                        alu_op_o,
  output logic [XLEN-1:0]                alu_a_o,
  output logic [XLEN-1:0]                alu_b_o,
  input  logic [XLEN-1:0]                alu_res_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [1:0]                     rsp_id_o,
  output logic [TAGW-1:0]                rsp_tag_o,
  output logic [XLEN-1:0]                rsp_data_o,
  output logic                           rsp_err_o
);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [1:0]       r_ptr;
  logic [1:0]       w_ptr_nxt;
  logic [NREQ-1:0]  w_gnt;
  logic [NREQ-1:0]  w_ready;
  logic             w_slot_free;
  logic             w_hs;
  logic [1:0]       w_gnt_idx;
  logic [TAGW-1:0]  w_tag;
  logic             w_illegal;

  logic [1:0]       r_rsp_id;
  logic [TAGW-1:0]  r_rsp_tag;
  logic [XLEN-1:0]  r_rsp_data;
  logic             r_rsp_err;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .i_req (req_valid_i),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt)
  );

  // The slot may be refilled in the same cycle the consumer drains it.
  assign w_slot_free = (r_state == ARB_EMPTY) || rsp_ready_i;
  assign w_ready     = (w_slot_free && !rst) ? w_gnt : '0;
  assign w_hs        = |w_ready;
  assign req_ready_o = w_ready;

  always_comb begin
    alu_op_o  = ALU_ADD;
    alu_a_o   = '0;
    alu_b_o   = '0;
    w_tag     = '0;
    w_gnt_idx = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_gnt[j]) begin
        alu_op_o  = req_op_i[j];
        alu_a_o   = req_a_i[j];
        alu_b_o   = req_b_i[j];
        w_tag     = req_tag_i[j];
        w_gnt_idx = 2'(j);
      end
    end
  end

  assign w_illegal = op_is_illegal(alu_op_o);
  assign w_ptr_nxt = (w_gnt_idx == 2'(NREQ - 1)) ? 2'd0 : w_gnt_idx + 2'd1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_EMPTY: if (w_hs) w_state_nxt = ARB_FULL;
      ARB_FULL: begin
        if (w_hs)             w_state_nxt = ARB_FULL;
        else if (rsp_ready_i) w_state_nxt = ARB_EMPTY;
      end
      default:   w_state_nxt = ARB_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ARB_EMPTY;
      r_ptr      <= '0;
      r_rsp_id   <= '0;
      r_rsp_tag  <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hs) begin
        r_ptr      <= w_ptr_nxt;
        r_rsp_id   <= w_gnt_idx;
        r_rsp_tag  <= w_tag;
        r_rsp_data <= w_illegal ? '0 : alu_res_i;
        r_rsp_err  <= w_illegal;
      end
    end
  end

  assign rsp_valid_o = (r_state == ARB_FULL);
  assign rsp_id_o    = r_rsp_id;
  assign rsp_tag_o   = r_rsp_tag;
  assign rsp_data_o  = r_rsp_data;
  assign rsp_err_o   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module : tb_alu_arbiter
// Directed + randomized-backpressure scoreboard bench for alu_arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_arbiter;
  import riscv_pkg::*;

  localparam int NREQ = 3;
  localparam int TAGW = 5;

  typedef struct packed {
    logic [1:0]      id;
    logic [TAGW-1:0] tag;
    logic [XLEN-1:0] data;
    logic            err;
  } exp_t;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  alu_op_t [NREQ-1:0]         req_op;
  logic [NREQ-1:0][XLEN-1:0]  req_a;
  logic [NREQ-1:0][XLEN-1:0]  req_b;
  logic [NREQ-1:0][TAGW-1:0]  req_tag;
  alu_op_t                    alu_op;
  logic [XLEN-1:0]            alu_a;
  logic [XLEN-1:0]            alu_b;
  logic [XLEN-1:0]            alu_res;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [1:0]                 rsp_id;
  logic [TAGW-1:0]            rsp_tag;
  logic [XLEN-1:0]            rsp_data;
  logic                       rsp_err;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  logic m_full  = 1'b0;
  logic m_known = 1'b0;
  int   m_ptr   = 0;
  int   last_g  = -1;

  always #5 clk = ~clk;

  alu_arbiter #(
    .NREQ (NREQ),
    .TAGW (TAGW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op_i    (req_op),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_tag_i   (req_tag),
    .alu_op_o    (alu_op),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_res_i   (alu_res),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_tag_o   (rsp_tag),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err)
  );

  function automatic logic [XLEN-1:0] alu_fn(input alu_op_t op, input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'd0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  // External ALU stub; garbage on illegal ops so the arbiter must zero it.
  always_comb alu_res = alu_fn(alu_op, alu_a, alu_b);

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    int   g;
    exp_t e;
    #1;
    g = (rst || (m_full && !rsp_ready)) ? -1 : rr_pick(req_valid, m_ptr);
    chk("req_ready", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
    if (g >= 0) begin
      chk("alu_op", 64'(alu_op), 64'(req_op[g]));
      chk("alu_a", 64'(alu_a), 64'(req_a[g]));
      chk("alu_b", 64'(alu_b), 64'(req_b[g]));
    end else if (!rst && req_valid == '0) begin
      chk("alu_idle", {alu_a, alu_b}, 64'd0);
      chk("alu_idle_op", 64'(alu_op), 64'(ALU_ADD));
    end
    if (m_known) begin
      chk("rsp_valid", 64'(rsp_valid), 64'(m_full));
      if (m_full) begin
        chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb[0];
          chk("rsp_id", 64'(rsp_id), 64'(e.id));
          chk("rsp_tag", 64'(rsp_tag), 64'(e.tag));
          chk("rsp_data", 64'(rsp_data), 64'(e.data));
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          if (rsp_ready && !rst) void'(sb.pop_front());
        end
      end
    end
    if (rst) begin
      m_full  = 1'b0;
      m_ptr   = 0;
      m_known = 1'b1;
      sb.delete();
    end else if (g >= 0) begin
      e.id   = 2'(g);
      e.tag  = req_tag[g];
      e.err  = op_is_illegal(req_op[g]);
      e.data = e.err ? '0 : alu_fn(req_op[g], req_a[g], req_b[g]);
      sb.push_back(e);
      m_ptr  = (g + 1) % NREQ;
      m_full = 1'b1;
    end else if (rsp_ready) begin
      m_full = 1'b0;
    end
    last_g = g;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    rsp_ready = 1'b0;
    req_valid = 3'b001;
    req_op    = {ALU_ADD, ALU_ADD, ALU_ADD};
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;
    @(negedge clk);

    // Reset for two cycles with a pending request: nothing may be accepted.
    cycle();
    cycle();
    rst = 1'b0;
    req_valid = '0;
    cycle();

    // Single request.
    req_valid = 3'b001; req_op[0] = ALU_ADD; req_a[0] = 32'd5; req_b[0] = 32'd7;
    req_tag[0] = 5'd3; rsp_ready = 1'b1;
    cycle();
    req_valid = '0;
    cycle();

    // Contention between requesters 0 and 1.
    req_valid = 3'b011;
    req_op[0] = ALU_SUB; req_a[0] = 32'd20; req_b[0] = 32'd3; req_tag[0] = 5'd1;
    req_op[1] = ALU_XOR; req_a[1] = 32'hF0F0; req_b[1] = 32'h0FF0; req_tag[1] = 5'd2;
    for (int n = 0; n < 4; n++) cycle();

    // Backpressure for three cycles, then drain and refill together.
    rsp_ready = 1'b0;
    for (int n = 0; n < 3; n++) cycle();
    rsp_ready = 1'b1;
    cycle();
    req_valid = '0;
    cycle();

    // Illegal opcode from requester 1.
    req_valid = 3'b010; req_op[1] = alu_op_t'(4'd12); req_a[1] = 32'd1; req_b[1] = 32'd1;
    req_tag[1] = 5'd9;
    cycle();
    req_valid = '0;
    cycle();

    // Random backpressure with all three requesters and varied payloads.
    req_op[0] = ALU_SLL;  req_a[0] = 32'h1;        req_b[0] = 32'd31;
    req_op[1] = ALU_SRA;  req_a[1] = 32'h8000_0000; req_b[1] = 32'd4;
    req_op[2] = ALU_SLTU; req_a[2] = 32'd1;        req_b[2] = 32'hFFFF_FFFF;
    req_tag   = {5'd22, 5'd11, 5'd7};
    for (int n = 0; n < 30; n++) begin
      rsp_ready = 1'($urandom_range(0, 1));
      for (int j = 0; j < NREQ; j++) begin
        if (!req_valid[j]) req_valid[j] = 1'($urandom_range(0, 1));
      end
      cycle();
      if (last_g >= 0) begin
        req_valid[last_g] = 1'b0;
        req_op[last_g]    = alu_op_t'(4'($urandom_range(0, 15)));
        req_a[last_g]     = $urandom;
        req_b[last_g]     = $urandom;
        req_tag[last_g]   = 5'($urandom_range(0, 31));
      end
    end
    req_valid = '0; rsp_ready = 1'b1;
    cycle();

    // Reset while a result is held: it must be discarded and ptr cleared.
    req_valid = 3'b010; req_op[1] = ALU_OR; req_a[1] = 32'h10; req_b[1] = 32'h01;
    cycle();
    req_valid = '0; rsp_ready = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0; rsp_ready = 1'b1; req_valid = 3'b110;
    req_op[2] = ALU_AND; req_a[2] = 32'hFF; req_b[2] = 32'h0F;
    cycle();
    req_valid = '0;
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters sharing the ALU, legal range 2..4.
REQ-002 SHALL have parameter TAGW, default 5, width of the per-request tag returned with the result.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid_i  input  NREQ  per-requester request valid.
REQ-006 SHALL have port req_ready_o  output  NREQ  per-requester accept; at most one bit set per cycle.
REQ-007 SHALL have port req_op_i  input  NREQ x alu_op_t  requested ALU operation.
REQ-008 SHALL have port req_a_i, req_b_i  input  NREQ x XLEN  operands.
REQ-009 SHALL have port req_tag_i  input  NREQ x TAGW  opaque tag.
REQ-010 SHALL have port alu_op_o  output  alu_op_t  operation driven to the shared combinational ALU.
REQ-011 SHALL have port alu_a_o, alu_b_o  output  XLEN  operands driven to the ALU.
REQ-012 SHALL have port alu_res_i  input  XLEN  ALU result, same cycle as alu_*_o.
REQ-013 SHALL have port rsp_valid_o  output  1  response register holds a result.
REQ-014 SHALL have port rsp_ready_i  input  1  consumer accepts response.
REQ-015 SHALL have port rsp_id_o  output  2  index of requester that owns the response.
REQ-016 SHALL have port rsp_tag_o  output  TAGW, rsp_data_o  output  XLEN, rsp_err_o  output  1.

Function
REQ-017 SHALL accept a request (handshake) in a cycle where req_valid_i[i] and req_ready_o[i] are both 1.
REQ-018 SHALL assert req_ready_o only when the response slot is free: state EMPTY, or state FULL with rsp_ready_i=1 (same-cycle drain and refill).
REQ-019 SHALL grant by round-robin: priority starts at pointer ptr, searching ptr, ptr+1, ... mod NREQ; the first valid requester wins.
REQ-020 SHALL update ptr to (granted index + 1) mod NREQ only on a completed handshake; ptr holds otherwise.
REQ-021 SHALL drive alu_op_o/alu_a_o/alu_b_o from the granted requester's inputs combinationally; with no grant, drive ALU_ADD and zero operands.
REQ-022 SHALL capture alu_res_i, granted index, and tag into the response register on the handshake edge; rsp_valid_o rises the next cycle (latency 1).
REQ-023 SHALL use a 2-state FSM: EMPTY -> FULL on handshake; FULL -> EMPTY on rsp_ready_i with no new handshake; FULL -> FULL on drain plus refill.
REQ-024 SHALL hold rsp_* stable while rsp_valid_o=1 and rsp_ready_i=0.
REQ-025 SHALL treat op encodings above ALU_AND (10..15) as illegal: accept normally, rsp_data_o=0, rsp_err_o=1; otherwise rsp_err_o=0.
REQ-026 SHALL guarantee that a requester holding valid is granted within NREQ handshakes.
REQ-027 SHALL ignore req_valid_i bits at index >= NREQ; requesters must hold valid and payload stable until accepted.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, set state EMPTY, ptr=0, rsp_valid_o=0, rsp_id_o=0, rsp_tag_o=0, rsp_data_o=0, rsp_err_o=0.
REQ-029 SHALL hold req_ready_o=0 during any cycle with rst=1; a held result mid-operation is discarded, not delivered.

Structure
REQ-030 SHALL take XLEN and alu_op_t from riscv_pkg; SHALL add localparam ALU_OP_LAST = ALU_AND and typedef arb_state_t {ARB_EMPTY, ARB_FULL} to riscv_pkg.
REQ-031 SHALL place the round-robin picker in one sub-module, rr_arbiter (inputs: request vector, ptr; output: one-hot grant).

Verification
REQ-032 Reset then idle: rst=1 for 2 cycles -> rsp_valid_o=0, req_ready_o=0 during reset, ptr=0 after.
REQ-033 Single request: req0 ADD a=5 b=7 tag=3, rsp_ready_i=1 -> next cycle rsp_valid_o=1, data=12, id=0, tag=3, err=0.
REQ-034 Contention: req0 and req1 valid continuously, rsp_ready_i=1 -> grants alternate 0,1,0,1; one response per cycle.
REQ-035 Backpressure: response full, rsp_ready_i=0 for 3 cycles -> req_ready_o=0, rsp_* stable; ready=1 -> drain and refill same cycle.
REQ-036 Illegal op: req1 op=4'd12 a=b=1 -> rsp_data_o=0, rsp_err_o=1, id=1.
REQ-037 Reset mid-operation: rst=1 while FULL -> next cycle rsp_valid_o=0, ptr=0, held result never delivered.
